// File: rtl/tlul_burst_splitter.sv
// TL-UL burst splitter: turns host bursts into 8-byte single-beat device accesses
// and folds the per-beat device responses back into the burst response the host expects.
package tlul_pkg;
    localparam int TL_AW   = 32;
    localparam int TL_DW   = 64;
    localparam int TL_DBW  = TL_DW / 8;
    localparam int TL_SZW  = 3;
    localparam int TL_AIW  = 8;
    localparam int TL_DIW  = 1;
    localparam int TL_AUW  = 8;
    localparam int TL_DUW  = 8;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic                a_valid;
        logic [2:0]          a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic [TL_AUW-1:0]   a_user;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        logic [2:0]          d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic [TL_DUW-1:0]   d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;
endpackage

module tlul_burst_splitter
    import tlul_pkg::*;
#(
    parameter int MaxSize      = 6,
    parameter int BeatSizeLog2 = 3
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_h_i,
    output tl_d2h_t tl_h_o,
    output tl_h2d_t tl_d_o,
    input  tl_d2h_t tl_d_i
);
    localparam int CntW = MaxSize - BeatSizeLog2 + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GET_ISSUE = 2'd1,
        PUT       = 2'd2,
        RSP_WAIT  = 2'd3
    } state_e;

    state_e              r_state;
    logic [2:0]          r_opcode;
    logic [TL_SZW-1:0]   r_size;
    logic [TL_AIW-1:0]   r_source;
    logic [TL_AW-1:0]    r_base;
    logic [CntW-1:0]     r_issue_cnt;
    logic [CntW-1:0]     r_rsp_cnt;
    logic                r_sticky_err;

    logic [CntW-1:0]     w_h_n;
    logic [CntW-1:0]     w_n;
    logic [CntW-1:0]     w_last;
    logic                w_is_put;
    logic                w_dev_a_hs;
    logic                w_dev_d_hs;
    logic                w_unused;

    function automatic logic is_put_op(input logic [2:0] op);
        return (op == PutFullData) || (op == PutPartialData);
    endfunction

    // Oversize and unknown opcodes stay single-beat so the downstream error logic sees them untouched.
    function automatic logic [CntW-1:0] beat_count(input logic [2:0] op, input logic [TL_SZW-1:0] size);
        logic [CntW-1:0] n;
        if (!(is_put_op(op) || (op == Get)) || (size <= TL_SZW'(BeatSizeLog2)) ||
            (size > TL_SZW'(MaxSize))) begin
            n = CntW'(1);
        end else begin
            n = CntW'(1) << (size - TL_SZW'(BeatSizeLog2));
        end
        return n;
    endfunction

    function automatic logic [TL_AW-1:0] beat_addr(input logic [TL_AW-1:0] base,
                                                   input logic [TL_SZW-1:0] size,
                                                   input logic [CntW-1:0] idx);
        logic [TL_AW-1:0] low_mask;
        low_mask = (TL_AW'(1) << size) - TL_AW'(1);
        return (base & ~low_mask) | (TL_AW'(idx) << BeatSizeLog2);
    endfunction

    assign w_h_n      = beat_count(tl_h_i.a_opcode, tl_h_i.a_size);
    assign w_n        = beat_count(r_opcode, r_size);
    assign w_last     = w_n - CntW'(1);
    assign w_is_put   = is_put_op(r_opcode) && (w_n != CntW'(1));
    assign w_dev_a_hs = tl_d_o.a_valid & tl_d_i.a_ready;
    assign w_dev_d_hs = tl_d_i.d_valid & tl_d_o.d_ready;
    assign w_unused   = ^{tl_d_i.d_size, tl_d_i.d_source};

    // Device A / host D steering: zero-latency pass-through with per-beat rewriting.
    always_comb begin
        tl_d_o = '0;
        tl_h_o = '0;
        case (r_state)
            IDLE: begin
                tl_d_o          = tl_h_i;
                tl_d_o.a_valid  = tl_h_i.a_valid & rst_ni;
                tl_d_o.a_user   = '0;
                if (w_h_n != CntW'(1)) begin
                    tl_d_o.a_size    = TL_SZW'(BeatSizeLog2);
                    tl_d_o.a_address = beat_addr(tl_h_i.a_address, tl_h_i.a_size, CntW'(0));
                end else begin
                    tl_d_o.a_size    = tl_h_i.a_size;
                end
                tl_h_o.a_ready  = tl_d_i.a_ready & rst_ni;
            end
            GET_ISSUE: begin
                tl_d_o.a_valid   = 1'b1;
                tl_d_o.a_opcode  = Get;
                tl_d_o.a_param   = tl_h_i.a_param;
                tl_d_o.a_size    = TL_SZW'(BeatSizeLog2);
                tl_d_o.a_source  = r_source;
                tl_d_o.a_address = beat_addr(r_base, r_size, r_issue_cnt);
                tl_d_o.a_mask    = '1;
            end
            PUT: begin
                tl_d_o           = tl_h_i;
                tl_d_o.a_user    = '0;
                tl_d_o.a_size    = TL_SZW'(BeatSizeLog2);
                tl_d_o.a_address = beat_addr(r_base, r_size, r_issue_cnt);
                tl_h_o.a_ready   = tl_d_i.a_ready;
            end
            RSP_WAIT: begin
                tl_d_o.a_param = tl_h_i.a_param;
            end
            default: begin
                tl_d_o.a_valid = 1'b0;
            end
        endcase

        // Responses never run ahead of issued beats; early Put acks are swallowed.
        if (r_state == IDLE) begin
            tl_d_o.d_ready = 1'b0;
        end else if (r_rsp_cnt >= r_issue_cnt) begin
            tl_d_o.d_ready = 1'b0;
        end else if (w_is_put && (r_rsp_cnt != w_last)) begin
            tl_d_o.d_ready = 1'b1;
        end else begin
            tl_h_o.d_valid  = tl_d_i.d_valid;
            tl_h_o.d_opcode = tl_d_i.d_opcode;
            tl_h_o.d_param  = tl_d_i.d_param;
            tl_h_o.d_size   = r_size;
            tl_h_o.d_source = r_source;
            tl_h_o.d_sink   = tl_d_i.d_sink;
            tl_h_o.d_data   = tl_d_i.d_data;
            tl_h_o.d_user   = tl_d_i.d_user;
            tl_h_o.d_error  = tl_d_i.d_error | (w_is_put & r_sticky_err);
            tl_d_o.d_ready  = tl_h_i.d_ready;
        end
    end

    // Transaction FSM with issue/response beat counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_opcode     <= 3'h0;
            r_size       <= '0;
            r_source     <= '0;
            r_base       <= '0;
            r_issue_cnt  <= '0;
            r_rsp_cnt    <= '0;
            r_sticky_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dev_a_hs) begin
                        r_opcode     <= tl_h_i.a_opcode;
                        r_size       <= tl_h_i.a_size;
                        r_source     <= tl_h_i.a_source;
                        r_base       <= tl_h_i.a_address;
                        r_issue_cnt  <= CntW'(1);
                        r_rsp_cnt    <= CntW'(0);
                        r_sticky_err <= 1'b0;
                        if (w_h_n == CntW'(1)) begin
                            r_state <= RSP_WAIT;
                        end else if (tl_h_i.a_opcode == Get) begin
                            r_state <= GET_ISSUE;
                        end else begin
                            r_state <= PUT;
                        end
                    end
                end
                GET_ISSUE, PUT: begin
                    if (w_dev_a_hs) begin
                        r_issue_cnt <= r_issue_cnt + CntW'(1);
                        if (r_issue_cnt == w_last) begin
                            r_state <= RSP_WAIT;
                        end
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase

            if ((r_state != IDLE) && w_dev_d_hs) begin
                r_rsp_cnt    <= r_rsp_cnt + CntW'(1);
                r_sticky_err <= r_sticky_err | tl_d_i.d_error;
                if (r_rsp_cnt == w_last) begin
                    r_state      <= IDLE;
                    r_sticky_err <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_tlul_burst_splitter.sv
// Directed bench for tlul_burst_splitter: host driver, device responder and
// scoreboard queues all advance from one initial block, one clock per cycle() call.
module tb_tlul_burst_splitter;
    import tlul_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [7:0]  src;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
    } a_beat_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [7:0]  src;
        logic [63:0] data;
        logic        err;
    } d_beat_t;

    logic    clk_i = 1'b0;
    logic    rst_ni;
    tl_h2d_t tl_h_i;
    tl_d2h_t tl_h_o;
    tl_h2d_t tl_d_o;
    tl_d2h_t tl_d_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int a_hs_cnt = 0;
    int hd_cnt = 0;
    int first_a_cyc = 0;
    int last_a_cyc = 0;
    int dev_push_cnt = 0;
    int dev_err_idx = -1;
    logic h_dready = 1'b1;
    logic ar_toggle = 1'b0;

    a_beat_t host_q[$];
    a_beat_t exp_a[$];
    d_beat_t exp_d[$];
    d_beat_t dev_rsp[$];

    tlul_burst_splitter #(.MaxSize(6), .BeatSizeLog2(3)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .tl_h_i(tl_h_i),
        .tl_h_o(tl_h_o),
        .tl_d_o(tl_d_o),
        .tl_d_i(tl_d_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dev_data(input logic [31:0] a);
        return {~a, a};
    endfunction

    function automatic logic [63:0] put_data(input logic [31:0] a, input int i);
        return {a, 32'(i)} ^ 64'hA5A5_A5A5_0000_0000;
    endfunction

    function automatic int beats(input logic [2:0] op, input logic [2:0] size);
        if (!((op == Get) || (op == PutFullData) || (op == PutPartialData)) || (size <= 3'd3) || (size > 3'd6))
            return 1;
        return 1 << (size - 3'd3);
    endfunction

    // Queue host beats plus every device beat and host response the transaction must produce.
    task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [31:0] addr,
                        input logic [7:0] src, input logic [7:0] mask, input logic exp_err);
        int n;
        logic [31:0] da;
        n = beats(op, size);
        for (int i = 0; i < ((op == Get) ? 1 : n); i++)
            host_q.push_back('{op: op, size: size, src: src, addr: addr, mask: mask,
                               data: (op == Get) ? 64'h0 : put_data(addr, i)});
        for (int i = 0; i < n; i++) begin
            da = (n == 1) ? addr : ((addr & ~((32'h1 << size) - 32'h1)) + 32'(8 * i));
            exp_a.push_back('{op: op, size: (n == 1) ? size : 3'd3, src: src, addr: da,
                              mask: ((n > 1) && (op == Get)) ? 8'hFF : mask,
                              data: (op == Get) ? 64'h0 : put_data(addr, i)});
            if (op == Get)
                exp_d.push_back('{op: AccessAckData, size: size, src: src, data: dev_data(da), err: 1'b0});
        end
        if (op != Get)
            exp_d.push_back('{op: AccessAck, size: size, src: src, data: 64'h0, err: exp_err});
    endtask

    // One clock: observe handshakes at the falling edge, drive new inputs just after the rising edge.
    task automatic cycle();
        a_beat_t ob;
        d_beat_t od;
        d_beat_t rb;
        @(negedge clk_i);
        cyc++;
        if (tl_d_o.a_valid && tl_d_i.a_ready) begin
            ob = '{op: tl_d_o.a_opcode, size: tl_d_o.a_size, src: tl_d_o.a_source,
                   addr: tl_d_o.a_address, mask: tl_d_o.a_mask, data: tl_d_o.a_data};
            if (exp_a.size() == 0) check("dev_a_extra", 128'(exp_a.size()), 128'(1));
            else check("dev_a_beat", ob, exp_a.pop_front());
            if (a_hs_cnt == 0) first_a_cyc = cyc;
            last_a_cyc = cyc;
            a_hs_cnt++;
            rb.op   = (tl_d_o.a_opcode == Get) ? AccessAckData : AccessAck;
            rb.size = tl_d_o.a_size;
            rb.src  = tl_d_o.a_source;
            rb.data = (tl_d_o.a_opcode == Get) ? dev_data(tl_d_o.a_address) : 64'h0;
            rb.err  = (dev_push_cnt == dev_err_idx);
            dev_push_cnt++;
            dev_rsp.push_back(rb);
        end
        if (tl_d_i.d_valid && tl_d_o.d_ready) void'(dev_rsp.pop_front());
        if (tl_h_o.d_valid && tl_h_i.d_ready) begin
            od = '{op: tl_h_o.d_opcode, size: tl_h_o.d_size, src: tl_h_o.d_source,
                   data: tl_h_o.d_data, err: tl_h_o.d_error};
            if (exp_d.size() == 0) check("host_d_extra", 128'(exp_d.size()), 128'(1));
            else check("host_d_beat", od, exp_d.pop_front());
            hd_cnt++;
        end
        if (tl_h_i.a_valid && tl_h_o.a_ready) void'(host_q.pop_front());
        @(posedge clk_i);
        #1;
        if (host_q.size() != 0) begin
            tl_h_i.a_valid   = 1'b1;
            tl_h_i.a_opcode  = host_q[0].op;
            tl_h_i.a_size    = host_q[0].size;
            tl_h_i.a_source  = host_q[0].src;
            tl_h_i.a_address = host_q[0].addr;
            tl_h_i.a_mask    = host_q[0].mask;
            tl_h_i.a_data    = host_q[0].data;
        end else begin
            tl_h_i.a_valid = 1'b0;
        end
        tl_h_i.d_ready = h_dready;
        tl_d_i.a_ready = ar_toggle ? ~tl_d_i.a_ready : 1'b1;
        if (dev_rsp.size() != 0) begin
            tl_d_i.d_valid  = 1'b1;
            tl_d_i.d_opcode = dev_rsp[0].op;
            tl_d_i.d_size   = dev_rsp[0].size;
            tl_d_i.d_source = dev_rsp[0].src;
            tl_d_i.d_data   = dev_rsp[0].data;
            tl_d_i.d_error  = dev_rsp[0].err;
        end else begin
            tl_d_i.d_valid = 1'b0;
        end
    endtask

    task automatic run(input string tag, input int budget);
        int n;
        n = 0;
        while (((host_q.size() + exp_a.size() + exp_d.size() + dev_rsp.size()) != 0) && (n < budget)) begin
            cycle();
            n++;
        end
        check({tag, "_drained"}, 128'(exp_a.size() + exp_d.size()), 128'(0));
    endtask

    initial begin
        tl_h_i = '0;
        tl_d_i = '0;
        rst_ni = 1'b0;
        tl_h_i.a_valid = 1'b1;
        tl_d_i.a_ready = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_dev_a_valid", tl_d_o.a_valid, 1'b0);
        check("rst_host_d_valid", tl_h_o.d_valid, 1'b0);
        check("rst_host_a_ready", tl_h_o.a_ready, 1'b0);
        tl_h_i.a_valid = 1'b0;
        tl_h_i.d_ready = 1'b1;
        rst_ni = 1'b1;
        #1;
        check("idle_host_a_ready", tl_h_o.a_ready, 1'b1);

        a_hs_cnt = 0;
        hd_cnt = 0;
        send(Get, 3'd6, 32'h100, 8'd5, 8'hFF, 1'b0);
        run("get_burst", 100);
        check("get_dev_beats", 128'(a_hs_cnt), 128'(8));
        check("get_consecutive", 128'(last_a_cyc - first_a_cyc), 128'(7));
        check("get_host_beats", 128'(hd_cnt), 128'(8));

        hd_cnt = 0;
        send(PutFullData, 3'd5, 32'h40, 8'd7, 8'hFF, 1'b0);
        run("put_burst", 100);
        check("put_host_acks", 128'(hd_cnt), 128'(1));

        hd_cnt = 0;
        dev_push_cnt = 0;
        dev_err_idx = 1;
        send(PutFullData, 3'd5, 32'h40, 8'd7, 8'hFF, 1'b1);
        run("err_put", 100);
        dev_err_idx = -1;
        send(PutPartialData, 3'd3, 32'h40, 8'd7, 8'h0F, 1'b0);
        run("err_cleared", 100);
        check("err_host_acks", 128'(hd_cnt), 128'(2));

        ar_toggle = 1'b1;
        a_hs_cnt = 0;
        hd_cnt = 0;
        send(Get, 3'd6, 32'h200, 8'd2, 8'hFF, 1'b0);
        for (int k = 0; (k < 200) && ((exp_a.size() + exp_d.size()) != 0); k++) begin
            h_dready = (k < 3) || (k >= 8);
            cycle();
            #1;
            if ((a_hs_cnt > 0) && (hd_cnt < 8)) check("bp_host_a_ready", tl_h_o.a_ready, 1'b0);
        end
        h_dready = 1'b1;
        ar_toggle = 1'b0;
        check("bp_drained", 128'(exp_a.size() + exp_d.size()), 128'(0));
        check("bp_dev_beats", 128'(a_hs_cnt), 128'(8));
        check("bp_host_beats", 128'(hd_cnt), 128'(8));
        cycle();

        hd_cnt = 0;
        send(Get, 3'd2, 32'h104, 8'd3, 8'hF0, 1'b0);
        run("single", 50);
        check("single_host_beats", 128'(hd_cnt), 128'(1));

        a_hs_cnt = 0;
        send(Get, 3'd6, 32'h300, 8'd1, 8'hFF, 1'b0);
        for (int k = 0; (k < 50) && (a_hs_cnt < 3); k++) cycle();
        check("rst_mid_issued", 128'(a_hs_cnt), 128'(3));
        #1 rst_ni = 1'b0;
        #1;
        check("rst_mid_dev_a_valid", tl_d_o.a_valid, 1'b0);
        check("rst_mid_host_d_valid", tl_h_o.d_valid, 1'b0);
        host_q.delete();
        exp_a.delete();
        exp_d.delete();
        dev_rsp.delete();
        tl_h_i.a_valid = 1'b0;
        tl_d_i.d_valid = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        hd_cnt = 0;
        send(Get, 3'd3, 32'h308, 8'd4, 8'hFF, 1'b0);
        run("post_rst", 50);
        check("post_rst_host_beats", 128'(hd_cnt), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tlul_burst_splitter.md
Name: tlul_burst_splitter

Overview:
- Sits directly upstream of the scratchpad TL-UL slave port.
- Converts multi-beat TL-UL bursts from the RocketChip side into single-beat, 8-byte transactions the scratchpad can service.
- Reassembles the scratchpad's per-beat responses into the burst response the host expects.
- Handles one host transaction at a time.

Parameters:
MaxSize, 6, log2 of the largest burst in bytes that is split (64 B = 8 beats)
BeatSizeLog2, 3, log2 of bus bytes per beat; must equal log2(top_pkg::TL_DW/8)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
tl_h_i  input  tl_h2d_t  host-side A channel plus d_ready
tl_h_o  output  tl_d2h_t  host-side D channel plus a_ready
tl_d_o  output  tl_h2d_t  device-side (scratchpad) A channel plus d_ready
tl_d_i  input  tl_d2h_t  device-side D channel plus a_ready

Behaviour:
- Reset (asynchronous, rst_ni low):
  - State returns to IDLE; beat counters and sticky error clear.
  - tl_d_o.a_valid = 0 and tl_h_o.d_valid = 0.
  - Any in-flight transaction is dropped; no response is owed after reset.
- Beat count N:
  - N = 1 when a_size <= BeatSizeLog2, or when a_size > MaxSize (pass-through; downstream tlul_err flags oversize).
  - Otherwise N = 2^(a_size - BeatSizeLog2).
- Beat address: beat i goes to {base[AW-1:a_size], i, BeatSizeLog2 zeros}.
- States: IDLE, GET_ISSUE, PUT, RSP_WAIT.
- IDLE:
  - Host A is combinationally passed to device A: a_valid, a_ready and all fields.
  - For N>1, a_size is rewritten to BeatSizeLog2 and address low bits are forced per beat with i = 0.
  - On A handshake, latch opcode, size, source and base address, and set issue_cnt = 1, rsp_cnt = 0.
  - Next state by opcode: N=1 → RSP_WAIT; Get → GET_ISSUE; PutFullData/PutPartialData → PUT.
- GET_ISSUE:
  - tl_h_o.a_ready = 0.
  - Splitter drives device A with a Get: latched source, size = BeatSizeLog2, mask all ones, beat address issue_cnt.
  - issue_cnt increments on each device handshake, at most one beat per cycle.
  - After beat N-1 is accepted → RSP_WAIT.
- PUT:
  - Host A beats pass through with device a_ready/a_valid coupling.
  - Size is rewritten and address forced per beat; mask and data are unmodified.
  - After beat N-1 is accepted → RSP_WAIT.
- Response path (all non-IDLE states; responses may overlap issue):
  - Get responses:
    - Every device D beat is forwarded to the host with d_size = latched size and d_source = latched source.
    - Data, opcode and error pass through.
    - tl_d_o.d_ready = tl_h_i.d_ready.
  - Put responses:
    - The first N-1 AccessAcks are absorbed: tl_d_o.d_ready = 1, host d_valid = 0, d_error ORed into sticky_err.
    - Ack N-1 is forwarded with d_size = latched size and d_error = sticky_err | d_error.
  - rsp_cnt increments on each device D handshake.
  - On the final beat's device D handshake → IDLE. That handshake is the host D handshake for N=1 and Get, and the absorbed/forwarded last ack for Put.
  - A new host A is accepted no earlier than the next cycle.
- Simultaneous events:
  - A device D handshake and a device A issue in the same cycle are both counted.
  - rsp_cnt never exceeds issue_cnt.
- Unsupported opcodes are handled as N=1 pass-through.
- Latency: zero added cycles on A and D. Extra issue cycles for a Get burst = N-1 minimum.
- tl_d_o.a_user = '0, tl_d_o.a_param = tl_h_i.a_param.

Test Plan:
- Get burst:
  - Stimulus: Get, size 6, address 0x100, source 5, device always ready.
  - Response: 8 device Gets at 0x100, 0x108 … 0x138, each size 3 with mask 0xFF, on 8 consecutive cycles.
  - Response: 8 host AccessAckData beats, all size 6 and source 5, data in order.
- PutFull burst:
  - Stimulus: PutFullData, size 5, address 0x40, 4 beats.
  - Response: 4 device Puts at 0x40 to 0x58.
  - Response: first 3 AccessAcks absorbed; exactly one host AccessAck with size 5.
- Error merge:
  - Stimulus: same 4-beat Put, device d_error = 1 on the 2nd ack only.
  - Response: the single host ack carries d_error = 1.
  - Response: the next transaction's error is 0 (sticky cleared).
- Backpressure:
  - Stimulus: Get size 6, device a_ready toggling 1/0 and host d_ready low for 5 cycles mid-burst.
  - Response: no beat is lost or duplicated; address order is preserved.
  - Response: host a_ready stays 0 until the 8th response handshake.
- Single-beat pass-through:
  - Stimulus: Get, size 2, address 0x104.
  - Response: device sees size 2, address 0x104 and the original mask; one response is returned to the host.
- Reset mid-burst:
  - Stimulus: assert rst_ni low after 3 of 8 Get beats are issued.
  - Response: a_valid and d_valid go to 0 asynchronously.
  - Response: after release, a fresh size-3 Get completes normally.
